// File: rtl/serv_decode_pkg.sv
// Shared opcode constants and predecode flag bundle for the decode queue.
package serv_decode_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef struct packed {
    logic branch_op;
    logic dbus_en;
    logic rd_op;
    logic two_stage_op;
    logic mdu_op;
    logic illegal;
  } pdec_t;

endpackage

// File: rtl/serv_predecode.sv
// Combinational classification of a fetched instruction word into class flags.
module serv_predecode
  import serv_decode_pkg::*;
#(
  parameter bit MDU = 1'b0
) (
  input  logic [31:0] i_wb_rdt,
  output pdec_t       o_pdec
);

  logic [4:0] op;
  logic [2:0] f3;
  logic       known_op;
  logic       m_ext;
  logic       unused_bits;

  assign op = i_wb_rdt[6:2];
  assign f3 = i_wb_rdt[14:12];
  // Register fields and immediates play no part in classification.
  assign unused_bits = ^{i_wb_rdt[31:26], i_wb_rdt[24:15], i_wb_rdt[11:7]};

  always_comb begin
    known_op = 1'b0;
    case (op)
      OP_LOAD, OP_MISC, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: known_op = 1'b1;
      default:                                       known_op = 1'b0;
    endcase
  end

  assign m_ext = (op == OP_OP) & i_wb_rdt[25];

  always_comb begin
    o_pdec              = '0;
    o_pdec.branch_op    = op[4];
    o_pdec.dbus_en      = ~op[2] & ~op[4];
    o_pdec.rd_op        = op[2] | (op[4] & op[0]) | (~op[3] & ~op[0]);
    o_pdec.mdu_op       = MDU & m_ext;
    o_pdec.two_stage_op = ~op[2]
                        | (f3[0] & ~f3[1] & ~op[0] & ~op[4])
                        | (f3[1] & ~f3[2] & ~op[0] & ~op[4])
                        | (MDU & m_ext);
    o_pdec.illegal      = (i_wb_rdt[1:0] != 2'b11) | ~known_op | (~MDU & m_ext);
  end

endmodule

// File: rtl/serv_decode_queue.sv
// Instruction FIFO between ibus and decode; words are classified on push and
// presented at the head with a valid/ready handshake.
module serv_decode_queue
  import serv_decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32,
  parameter bit          MDU   = 1'b0
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [31:0]              i_wb_rdt,
  input  logic                     i_wb_en,
  input  logic [PC_W-1:0]          i_pc,
  input  logic                     i_flush,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [29:0]              o_instr,
  output logic [PC_W-1:0]          o_pc,
  output logic                     o_branch_op,
  output logic                     o_dbus_en,
  output logic                     o_rd_op,
  output logic                     o_two_stage_op,
  output logic                     o_mdu_op,
  output logic                     o_illegal,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [29:0]     instr_q [DEPTH];
  logic [PC_W-1:0] pc_q    [DEPTH];
  pdec_t           pdec_q  [DEPTH];

  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  pdec_t push_pdec;
  pdec_t head;
  logic  valid;
  logic  pop;
  logic  push;
  logic  push_w;

  serv_predecode #(.MDU(MDU)) u_predecode (
    .i_wb_rdt (i_wb_rdt),
    .o_pdec   (push_pdec)
  );

  assign valid  = (count_q != '0);
  assign pop    = valid & i_ready;
  // A pop frees the slot the same cycle, so a full queue can still accept.
  assign push   = i_wb_en & (~full_q | pop);
  assign push_w = push & ~i_flush;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (i_wb_en & full_q & ~pop & ~i_flush);
    if (i_flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push) wptr_d = wptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pdec_q[i]  <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      if (push_w) begin
        instr_q[wptr_q] <= i_wb_rdt[31:2];
        pc_q[wptr_q]    <= i_pc;
        pdec_q[wptr_q]  <= push_pdec;
      end
    end
  end

  always_comb begin
    head    = valid ? pdec_q[rptr_q]  : '0;
    o_instr = valid ? instr_q[rptr_q] : '0;
    o_pc    = valid ? pc_q[rptr_q]    : '0;
  end

  assign o_valid        = valid;
  assign o_branch_op    = head.branch_op;
  assign o_dbus_en      = head.dbus_en;
  assign o_rd_op        = head.rd_op;
  assign o_two_stage_op = head.two_stage_op;
  assign o_mdu_op       = head.mdu_op;
  assign o_illegal      = head.illegal;
  assign o_count        = count_q;
  assign o_full         = full_q;
  assign o_ovf          = ovf_q;

endmodule
